// File: rtl/keypad_hex_entry.sv
// keypad_hex_entry: scans a 4x4 active-low keypad, debounces press and release,
// and shifts each accepted key code into an 8-digit hex entry register.
module keypad_hex_entry #(
   parameter int unsigned SCAN_DIV  = 131072,
   parameter int unsigned DEB_TICKS = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [3:0]  row_in,
   output logic [3:0]  col_out,
   input  logic        clr,
   output logic        key_valid,
   output logic [3:0]  key_code,
   output logic [31:0] data_out,
   output logic [3:0]  digit_cnt
);

   localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int unsigned CNT_W = $clog2(DEB_TICKS + 1);

   typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD} state_t;

   state_t             state_q, state_d;
   logic [3:0]         sync1_q, sync1_d;
   logic [3:0]         row_s_q, row_s_d;
   logic [DIV_W-1:0]   div_q, div_d;
   logic [1:0]         col_idx_q, col_idx_d;
   logic [3:0]         col_out_q, col_out_d;
   logic [1:0]         row_lat_q, row_lat_d;
   logic [1:0]         col_lat_q, col_lat_d;
   logic [3:0]         pat_q, pat_d;
   logic [CNT_W-1:0]   stab_q, stab_d;
   logic [CNT_W-1:0]   rel_q, rel_d;
   logic               accept_q, accept_d;
   logic               key_valid_q, key_valid_d;
   logic [3:0]         key_code_q, key_code_d;
   logic [31:0]        data_q, data_d;
   logic [3:0]         digit_q, digit_d;

   logic               tick_c;
   logic               one_low_c;
   logic [1:0]         low_idx_c;
   logic [3:0]         new_code_c;

   assign tick_c     = (div_q == DIV_W'(SCAN_DIV - 1));
   assign new_code_c = {row_lat_q, col_lat_q};

   // Exactly one row pulled low identifies a single closed key in the driven column.
   always_comb begin
      one_low_c = 1'b1;
      low_idx_c = 2'd0;
      unique case (row_s_q)
         4'b1110: low_idx_c = 2'd0;
         4'b1101: low_idx_c = 2'd1;
         4'b1011: low_idx_c = 2'd2;
         4'b0111: low_idx_c = 2'd3;
         default: one_low_c = 1'b0;
      endcase
   end

   // Scan/debounce FSM plus entry-register update.
   always_comb begin
      state_d     = state_q;
      sync1_d     = row_in;
      row_s_d     = sync1_q;
      div_d       = tick_c ? '0 : div_q + DIV_W'(1);
      col_idx_d   = col_idx_q;
      row_lat_d   = row_lat_q;
      col_lat_d   = col_lat_q;
      pat_d       = pat_q;
      stab_d      = stab_q;
      rel_d       = rel_q;
      accept_d    = 1'b0;
      key_valid_d = accept_q;
      key_code_d  = accept_q ? new_code_c : key_code_q;
      data_d      = data_q;
      digit_d     = digit_q;

      if (tick_c) begin
         unique case (state_q)
            SCAN: begin
               if (one_low_c) begin
                  row_lat_d = low_idx_c;
                  col_lat_d = col_idx_q;
                  pat_d     = row_s_q;
                  stab_d    = CNT_W'(1);
                  if (DEB_TICKS <= 32'd1) begin
                     state_d  = HELD;
                     accept_d = 1'b1;
                     rel_d    = '0;
                  end else begin
                     state_d = DEBOUNCE;
                  end
               end else begin
                  col_idx_d = col_idx_q + 2'd1;
               end
            end
            DEBOUNCE: begin
               if (row_s_q == pat_q) begin
                  stab_d = stab_q + CNT_W'(1);
                  if (stab_d == CNT_W'(DEB_TICKS)) begin
                     state_d  = HELD;
                     accept_d = 1'b1;
                     rel_d    = '0;
                  end
               end else begin
                  col_idx_d = col_idx_q + 2'd1;
                  state_d   = SCAN;
               end
            end
            HELD: begin
               if (row_s_q == 4'b1111) begin
                  rel_d = rel_q + CNT_W'(1);
                  if (rel_d == CNT_W'(DEB_TICKS)) begin
                     rel_d     = '0;
                     col_idx_d = col_idx_q + 2'd1;
                     state_d   = SCAN;
                  end
               end else begin
                  rel_d = '0;
               end
            end
            default: state_d = SCAN;
         endcase
      end

      col_out_d = ~(4'b0001 << col_idx_d);

      // A clear in the accept cycle keeps only the new digit.
      if (accept_q) begin
         if (clr) begin
            data_d  = {28'h0, new_code_c};
            digit_d = 4'd1;
         end else begin
            data_d  = {data_q[27:0], new_code_c};
            digit_d = (digit_q == 4'd8) ? 4'd8 : digit_q + 4'd1;
         end
      end else if (clr) begin
         data_d  = '0;
         digit_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= SCAN;
         sync1_q     <= 4'b1111;
         row_s_q     <= 4'b1111;
         div_q       <= '0;
         col_idx_q   <= 2'd0;
         col_out_q   <= 4'b1110;
         row_lat_q   <= 2'd0;
         col_lat_q   <= 2'd0;
         pat_q       <= 4'b1111;
         stab_q      <= '0;
         rel_q       <= '0;
         accept_q    <= 1'b0;
         key_valid_q <= 1'b0;
         key_code_q  <= 4'd0;
         data_q      <= '0;
         digit_q     <= 4'd0;
      end else begin
         state_q     <= state_d;
         sync1_q     <= sync1_d;
         row_s_q     <= row_s_d;
         div_q       <= div_d;
         col_idx_q   <= col_idx_d;
         col_out_q   <= col_out_d;
         row_lat_q   <= row_lat_d;
         col_lat_q   <= col_lat_d;
         pat_q       <= pat_d;
         stab_q      <= stab_d;
         rel_q       <= rel_d;
         accept_q    <= accept_d;
         key_valid_q <= key_valid_d;
         key_code_q  <= key_code_d;
         data_q      <= data_d;
         digit_q     <= digit_d;
      end
   end

   assign col_out   = col_out_q;
   assign key_valid = key_valid_q;
   assign key_code  = key_code_q;
   assign data_out  = data_q;
   assign digit_cnt = digit_q;

endmodule

// File: tb/tb_keypad_hex_entry.sv
// tb_keypad_hex_entry: directed keypad scenarios against a modelled 4x4 switch matrix.
module tb_keypad_hex_entry;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  row_in;
   logic [3:0]  col_out;
   logic        clr;
   logic        key_valid;
   logic [3:0]  key_code;
   logic [31:0] data_out;
   logic [3:0]  digit_cnt;

   logic [15:0] keys;
   int          n_vec  = 0;
   int          n_miss = 0;
   int          pulses = 0;

   keypad_hex_entry #(.SCAN_DIV(4), .DEB_TICKS(3)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .row_in    (row_in),
      .col_out   (col_out),
      .clr       (clr),
      .key_valid (key_valid),
      .key_code  (key_code),
      .data_out  (data_out),
      .digit_cnt (digit_cnt)
   );

   always #5 clk = ~clk;

   // Closed key (r,c) pulls row r low while column c is driven low.
   always_comb begin
      row_in = 4'hF;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (keys[4*r+c] && !col_out[c]) row_in[r] = 1'b0;
   end

   always @(negedge clk) if (key_valid) pulses++;

   initial begin
      #500000;
      $display("FAIL watchdog expired, got timeout, want completion");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Leaves the bench just after the tick edge on which col_out becomes v.
   task automatic wait_col_edge(input logic [3:0] v);
      int n = 0;
      while (col_out === v && n < 64) begin cyc(1); n++; end
      while (col_out !== v && n < 64) begin cyc(1); n++; end
      chk("wait_col", {28'h0, col_out}, {28'h0, v});
   endtask

   task automatic enter_key(input int k, input bit with_clr);
      int n = 0;
      keys[k] = 1'b1;
      if (with_clr) clr = 1'b1;
      while (!key_valid && n < 200) begin cyc(1); n++; end
      clr = 1'b0;
      chk("kv_seen", {31'h0, key_valid}, 32'd1);
      chk("key_code", {28'h0, key_code}, k);
      keys[k] = 1'b0;
      cyc(80);
   endtask

   initial begin
      int p0;
      int n;
      logic [3:0] ecol;

      keys  = '0;
      clr   = 1'b0;
      rst_n = 1'b0;

      // Reset held for three cycles.
      for (int i = 0; i < 3; i++) begin
         cyc(1);
         chk("rst_col", {28'h0, col_out}, 32'hE);
         chk("rst_data", data_out, 32'h0);
         chk("rst_cnt", {28'h0, digit_cnt}, 32'h0);
         chk("rst_kv", {31'h0, key_valid}, 32'h0);
      end
      rst_n = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         cyc(1);
         ecol = ~(4'b0001 << (k / 4));
         chk("rotate", {28'h0, col_out}, {28'h0, ecol});
      end

      // Key row1/col2 held for 40 ticks.
      keys[6] = 1'b1;
      cyc(160);
      chk("hold_pulses", pulses, 1);
      chk("hold_code", {28'h0, key_code}, 32'h6);
      chk("hold_data", data_out, 32'h6);
      chk("hold_cnt", {28'h0, digit_cnt}, 32'h1);
      chk("hold_col", {28'h0, col_out}, 32'hB);
      keys[6] = 1'b0;
      n = 0;
      while (col_out === 4'b1011 && n < 40) begin cyc(1); n++; end
      chk("rel_latency", {31'h0, (n >= 11 && n <= 14)}, 32'd1);
      chk("rel_col", {28'h0, col_out}, 32'h7);

      // Clear alone.
      clr = 1'b1;
      cyc(1);
      clr = 1'b0;
      chk("clr_data", data_out, 32'h0);
      chk("clr_cnt", {28'h0, digit_cnt}, 32'h0);
      chk("clr_code", {28'h0, key_code}, 32'h6);
      chk("clr_kv", {31'h0, key_valid}, 32'h0);

      // Keys 1..9; the oldest digit drops out.
      for (int k = 1; k <= 9; k++) enter_key(k, 1'b0);
      chk("seq_data", data_out, 32'h23456789);
      chk("seq_cnt", {28'h0, digit_cnt}, 32'h8);
      chk("seq_pulses", pulses, 10);

      // Clear coinciding with the accept of key A.
      enter_key(10, 1'b1);
      chk("clrkey_data", data_out, 32'hA);
      chk("clrkey_cnt", {28'h0, digit_cnt}, 32'h1);
      chk("clrkey_pulses", pulses, 11);

      // Bounce on row1/col2: one tick low, one tick high, twice.
      p0 = pulses;
      for (int b = 0; b < 2; b++) begin
         wait_col_edge(4'b1011);
         keys[6] = 1'b1;
         cyc(4);
         chk("deb_hold", {28'h0, col_out}, 32'hB);
         keys[6] = 1'b0;
         cyc(4);
         chk("deb_abort", {28'h0, col_out}, 32'h7);
      end
      cyc(40);
      chk("bounce_pulses", pulses, p0);
      wait_col_edge(4'b1110);

      // Two rows low on column 0.
      keys[4] = 1'b1;
      keys[8] = 1'b1;
      cyc(80);
      chk("dual_pulses", pulses, p0);
      wait_col_edge(4'b1101);
      keys = '0;
      cyc(40);

      // Reset mid-debounce (8) and with the accept pulse pending (12).
      for (int i = 8; i <= 12; i += 4) begin
         wait_col_edge(4'b1011);
         keys[6] = 1'b1;
         cyc(i);
         rst_n   = 1'b0;
         keys[6] = 1'b0;
         cyc(1);
         chk("abort_kv", {31'h0, key_valid}, 32'h0);
         chk("abort_col", {28'h0, col_out}, 32'hE);
         chk("abort_data", data_out, 32'h0);
         chk("abort_cnt", {28'h0, digit_cnt}, 32'h0);
         chk("abort_code", {28'h0, key_code}, 32'h0);
         cyc(1);
         rst_n = 1'b1;
         cyc(60);
         chk("abort_pulses", pulses, p0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
